// File: rtl/bf_io_port.sv
// Byte I/O responder for the bfX core: output FIFO feeding an 8N1 UART
// transmitter, input FIFO fed by a host valid/ready stream, and core stall.
module bf_io_port #(
    parameter int DEPTH_LOG2   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_out_strobe,
    input  logic [7:0]            i_out_byte,
    input  logic                  i_in_req,
    output logic [7:0]            o_in_byte,
    output logic                  o_stall,
    input  logic                  i_host_in_valid,
    input  logic [7:0]            i_host_in_data,
    output logic                  o_host_in_ready,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic [DEPTH_LOG2:0]   o_out_count,
    output logic [DEPTH_LOG2:0]   o_in_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0]         TIMER_MAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]            r_out_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_out_wr;
    logic [DEPTH_LOG2-1:0] r_out_rd;
    logic [DEPTH_LOG2:0]   r_out_count;

    logic [7:0]            r_in_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_in_wr;
    logic [DEPTH_LOG2-1:0] r_in_rd;
    logic [DEPTH_LOG2:0]   r_in_count;

    logic [1:0]            r_state;
    logic [TW-1:0]         r_timer;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_tx;

    logic w_out_full;
    logic w_out_empty;
    logic w_out_push;
    logic w_out_pop;
    logic w_in_full;
    logic w_in_empty;
    logic w_in_push;
    logic w_in_pop;

    // Full/empty come from pre-edge occupancy, so a same-cycle pop never unblocks a push.
    assign w_out_full  = (r_out_count == FULL_COUNT);
    assign w_out_empty = (r_out_count == '0);
    assign w_out_push  = i_out_strobe & ~w_out_full;
    assign w_out_pop   = (r_state == S_IDLE) & ~w_out_empty;

    assign w_in_full   = (r_in_count == FULL_COUNT);
    assign w_in_empty  = (r_in_count == '0);
    assign w_in_push   = i_host_in_valid & ~w_in_full;
    assign w_in_pop    = i_in_req & ~w_in_empty;

    assign o_stall         = (i_out_strobe & w_out_full) | (i_in_req & w_in_empty);
    assign o_in_byte       = w_in_empty ? 8'h00 : r_in_mem[r_in_rd];
    assign o_host_in_ready = ~w_in_full;
    assign o_tx            = r_tx;
    assign o_tx_busy       = (r_state != S_IDLE);
    assign o_out_count     = r_out_count;
    assign o_in_count      = r_in_count;

    // Storage is deliberately left out of reset; only pointers and counts clear.
    always_ff @(posedge i_clk) begin
        if (w_out_push) r_out_mem[r_out_wr] <= i_out_byte;
        if (w_in_push)  r_in_mem[r_in_wr]   <= i_host_in_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + PTR_ONE;
            if (w_out_pop)  r_out_rd <= r_out_rd + PTR_ONE;
            if (w_out_push && !w_out_pop)
                r_out_count <= r_out_count + CNT_ONE;
            else if (!w_out_push && w_out_pop)
                r_out_count <= r_out_count - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_wr    <= '0;
            r_in_rd    <= '0;
            r_in_count <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + PTR_ONE;
            if (w_in_pop)  r_in_rd <= r_in_rd + PTR_ONE;
            if (w_in_push && !w_in_pop)
                r_in_count <= r_in_count + CNT_ONE;
            else if (!w_in_push && w_in_pop)
                r_in_count <= r_in_count - CNT_ONE;
        end
    end

    // Each state or bit lasts until the down-counting timer reaches zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_out_empty) begin
                        r_shift <= r_out_mem[r_out_rd];
                        r_timer <= TIMER_MAX;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == '0) begin
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_timer <= TIMER_MAX;
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_timer <= TIMER_MAX;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_io_port.sv
// Self-checking bench for bf_io_port: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_bf_io_port;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int CPB   = 4;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         outStrobe = 1'b0;
    logic [7:0]   outByte = 8'h00;
    logic         inReq = 1'b0;
    logic         hostInValid = 1'b0;
    logic [7:0]   hostInData = 8'h00;
    logic [7:0]   inByte;
    logic         stall;
    logic         hostInReady;
    logic         tx;
    logic         txBusy;
    logic [DL2:0] outCount;
    logic [DL2:0] inCount;

    int checks = 0;
    int errors = 0;

    // Frame of 0x41 in line order: start, LSB-first data, stop.
    int frameSeq[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    logic [7:0] outQ[$];
    logic [7:0] inQ[$];
    bit         txActive = 1'b0;
    logic [7:0] txByte = 8'h00;
    int         txOffset = 0;

    bf_io_port #(.DEPTH_LOG2(DL2), .CLKS_PER_BIT(CPB)) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_out_strobe    (outStrobe),
        .i_out_byte      (outByte),
        .i_in_req        (inReq),
        .o_in_byte       (inByte),
        .o_stall         (stall),
        .i_host_in_valid (hostInValid),
        .i_host_in_data  (hostInData),
        .o_host_in_ready (hostInReady),
        .o_tx            (tx),
        .o_tx_busy       (txBusy),
        .o_out_count     (outCount),
        .o_in_count      (inCount)
    );

    always #5 clk = ~clk;

    function automatic logic expTx();
        int idx;
        if (!txActive) return 1'b1;
        idx = txOffset / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return txByte[idx-1];
        return 1'b1;
    endfunction

    function automatic bit modelStall();
        return (outStrobe && outQ.size() == DEPTH) || (inReq && inQ.size() == 0);
    endfunction

    function automatic logic [7:0] expInByte();
        return (inQ.size() > 0) ? inQ[0] : 8'h00;
    endfunction

    task automatic modelReset();
        outQ.delete();
        inQ.delete();
        txActive = 1'b0;
        txOffset = 0;
    endtask

    // Occupancy decisions use pre-edge state; the transmitter takes one idle cycle between frames.
    task automatic modelEdge();
        bit doOutPush;
        bit doTxStart;
        bit doInPush;
        bit doInPop;
        doOutPush = outStrobe && (outQ.size() < DEPTH);
        doTxStart = !txActive && (outQ.size() > 0);
        doInPush  = hostInValid && (inQ.size() < DEPTH);
        doInPop   = inReq && (inQ.size() > 0);
        if (txActive) begin
            txOffset++;
            if (txOffset == 10 * CPB) txActive = 1'b0;
        end else if (doTxStart) begin
            txByte   = outQ.pop_front();
            txActive = 1'b1;
            txOffset = 0;
        end
        if (doOutPush) outQ.push_back(outByte);
        if (doInPop) void'(inQ.pop_front());
        if (doInPush) inQ.push_back(hostInData);
    endtask

    always @(posedge clk) begin
        if (rstN) modelEdge();
    end

    task automatic checkLit(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkLit("tx",          32'(tx),          32'(expTx()));
        checkLit("txBusy",      32'(txBusy),      32'(txActive));
        checkLit("outCount",    32'(outCount),    32'(outQ.size()));
        checkLit("inCount",     32'(inCount),     32'(inQ.size()));
        checkLit("inByte",      32'(inByte),      32'(expInByte()));
        checkLit("stall",       32'(stall),       32'(modelStall()));
        checkLit("hostInReady", 32'(hostInReady), 32'(inQ.size() < DEPTH));
    endtask

    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input logic strobe, input logic [7:0] ob, input logic req,
                                 input logic hv, input logic [7:0] hd);
        outStrobe   = strobe;
        outByte     = ob;
        inReq       = req;
        hostInValid = hv;
        hostInData  = hd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkLit({tag, "Tx"},       32'(tx),          32'd1);
        checkLit({tag, "Busy"},     32'(txBusy),      32'd0);
        checkLit({tag, "OutCount"}, 32'(outCount),    32'd0);
        checkLit({tag, "InCount"},  32'(inCount),     32'd0);
        checkLit({tag, "InByte"},   32'(inByte),      32'h00);
        checkLit({tag, "Ready"},    32'(hostInReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rstN = 1'b1;
        tick();
        tick();

        // Single 0x41 frame, line checked against the literal bit sequence.
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j <= 40; j++) begin
            tick();
            checkLit("frameTx",   32'(tx),     32'((j < 40) ? frameSeq[j / CPB] : 1));
            checkLit("frameBusy", 32'(txBusy), 32'(j < 40));
        end

        // Burst into the output FIFO until it fills.
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            checkLit("burstNoStall", 32'(stall), 32'd0);
            tick();
        end
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
        checkLit("fullStall",    32'(stall),    32'd1);
        checkLit("fullOutCount", 32'(outCount), 32'd16);
        n = 0;
        while (stall && n < 200) begin
            tick();
            n++;
        end
        checkLit("stallReleaseCycles", 32'(n), 32'd26);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (760) tick();
        checkLit("drainOutCount", 32'(outCount), 32'd0);
        checkLit("drainBusy",     32'(txBusy),   32'd0);

        // Input path.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h2C);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkLit("inPathByte",  32'(inByte),  32'h2C);
        checkLit("inPathCount", 32'(inCount), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        checkLit("inPathStall", 32'(stall), 32'd0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkLit("inPathAfterPop", 32'(inCount), 32'd0);

        // Starvation then release by a host push.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            checkLit("starveStall", 32'(stall), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h7F);
        checkLit("starveStallPush", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        checkLit("starveRelease", 32'(stall),  32'd0);
        checkLit("starveByte",    32'(inByte), 32'h7F);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkLit("starveCount", 32'(inCount), 32'd0);

        // Fill the input FIFO, then alternate across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h80 + i));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkLit("inFullReady", 32'(hostInReady), 32'd0);
        checkLit("inFullCount", 32'(inCount),     32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'hEE);
        checkLit("inFullPopStall", 32'(stall),  32'd0);
        checkLit("inFullHead",     32'(inByte), 32'h80);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkLit("inBlockedCount", 32'(inCount), 32'd15);
        checkLit("inBlockedHead",  32'(inByte),  32'h81);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            else            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'hA0 + i));
            tick();
        end

        // Random traffic respecting the hold-while-stalled contract.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rstN = 1'b0;
                #1;
                checkResetState("midReset");
                modelReset();
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
                tick();
                rstN = 1'b1;
            end else begin
                int r;
                logic hv;
                hv = ($urandom_range(0, 3) < (((cyc / 500) % 2 == 0) ? 3 : 1));
                if (modelStall()) begin
                    hostInValid = hv;
                    hostInData  = 8'($urandom);
                    #1;
                end else begin
                    r = $urandom_range(0, 9);
                    applyStimulus(r < 3, 8'($urandom), (r >= 3) && (r < 6), hv, 8'($urandom));
                end
                tick();
            end
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
